// File: rtl/regfile_write_scheduler.sv
// Merges two write clients round-robin into one registered register-file write port via a small FIFO.
// Latency: accept at edge N -> we=1 after edge N+1; clients see ready=0 whenever the FIFO is full.
module regfile_write_scheduler #(
    parameter int unsigned DATA_W = 3,
    parameter int unsigned ADDR_W = 1,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   c0_valid,
    output logic                   c0_ready,
    input  logic [ADDR_W-1:0]      c0_addr,
    input  logic [DATA_W-1:0]      c0_data,
    input  logic                   c1_valid,
    output logic                   c1_ready,
    input  logic [ADDR_W-1:0]      c1_addr,
    input  logic [DATA_W-1:0]      c1_data,
    output logic                   we,
    output logic [ADDR_W-1:0]      waddr,
    output logic [DATA_W-1:0]      wdata,
    output logic [2**ADDR_W-1:0]   pending,
    output logic                   busy
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned NADDR = 2 ** ADDR_W;

    logic [ADDR_W-1:0] mem_addr_q [DEPTH];
    logic [DATA_W-1:0] mem_data_q [DEPTH];

    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rr_q, rr_d;
    logic              we_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [DATA_W-1:0] wdata_q;

    logic              space;
    logic              grant0;
    logic              grant1;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] push_addr;
    logic [DATA_W-1:0] push_data;
    logic [NADDR-1:0]  pend_mask;

    // rr_q=0 favours client 0 on contention; ready is held low while rst is asserted.
    always_comb begin
        space     = (count_q < CNT_W'(DEPTH));
        grant0    = !rst && space && c0_valid && (!c1_valid || !rr_q);
        grant1    = !rst && space && c1_valid && (!c0_valid || rr_q);
        push      = grant0 || grant1;
        pop       = (count_q != '0);
        push_addr = grant1 ? c1_addr : c0_addr;
        push_data = grant1 ? c1_data : c0_data;
        rr_d      = rr_q ^ (space && c0_valid && c1_valid);
        count_d   = count_q + CNT_W'(push) - CNT_W'(pop);
        head_d    = head_q;
        tail_d    = tail_q;
        if (pop) begin
            head_d = (head_q == PTR_W'(DEPTH - 1)) ? '0 : head_q + 1'b1;
        end
        if (push) begin
            tail_d = (tail_q == PTR_W'(DEPTH - 1)) ? '0 : tail_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            rr_q    <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            rr_q    <= rr_d;
            we_q    <= pop;
            if (pop) begin
                waddr_q <= mem_addr_q[head_q];
                wdata_q <= mem_data_q[head_q];
            end
        end
    end

    // Storage needs no reset: only entries covered by count_q are ever observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr_q[tail_q] <= push_addr;
            mem_data_q[tail_q] <= push_data;
        end
    end

    always_comb begin
        int idx;
        pend_mask = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            idx = int'(head_q) + k;
            if (idx >= int'(DEPTH)) begin
                idx = idx - int'(DEPTH);
            end
            if (k < int'(count_q)) begin
                pend_mask[mem_addr_q[idx]] = 1'b1;
            end
        end
        if (we_q) begin
            pend_mask[waddr_q] = 1'b1;
        end
    end

    assign c0_ready = grant0;
    assign c1_ready = grant1;
    assign we       = we_q;
    assign waddr    = waddr_q;
    assign wdata    = wdata_q;
    assign pending  = pend_mask;
    assign busy     = (count_q != '0) || we_q;

endmodule
